// File: rtl/pop_timers.sv
// rtl/pop_timers.sv - pump/MW/probe pulse sequencer with button-adjusted pi/2 and free-precession lengths; optional sample gate under macro POPTIMERS_SAMPLE_EN
`timescale 1ns/1ps

module pop_timers #(
    parameter int WIDTH     = 16,
    parameter int PUMP_LEN  = 1000,
    parameter int DEAD_LEN  = 25,
    parameter int PROBE_LEN = 250,
    parameter int PI2_DEF   = 50,
    parameter int PI2_MIN   = 1,
    parameter int PI2_MAX   = 1000,
    parameter int PI2_STEP  = 1,
    parameter int FREE_DEF  = 500,
    parameter int FREE_MIN  = 10,
    parameter int FREE_MAX  = 20000,
    parameter int FREE_STEP = 10
) (
    input  logic clk_2M5,
    input  logic reset,
    input  logic load_defaults,
    input  logic pieovertwo_plus,
    input  logic pieovertwo_minus,
    input  logic freeprecess_plus,
    input  logic freeprecess_minus,
    output logic pump,
    output logic probe,
    output logic MW,
    output logic sample
);

    localparam logic [WIDTH-1:0] L_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] L_PUMP      = WIDTH'(PUMP_LEN);
    localparam logic [WIDTH-1:0] L_DEAD      = WIDTH'(DEAD_LEN);
    localparam logic [WIDTH-1:0] L_PROBE     = WIDTH'(PROBE_LEN);
    localparam logic [WIDTH-1:0] L_PI2_DEF   = WIDTH'(PI2_DEF);
    localparam logic [WIDTH-1:0] L_PI2_MIN   = WIDTH'(PI2_MIN);
    localparam logic [WIDTH-1:0] L_PI2_MAX   = WIDTH'(PI2_MAX);
    localparam logic [WIDTH-1:0] L_PI2_STEP  = WIDTH'(PI2_STEP);
    localparam logic [WIDTH-1:0] L_PI2_HI    = WIDTH'(PI2_MAX - PI2_STEP);
    localparam logic [WIDTH-1:0] L_PI2_LO    = WIDTH'(PI2_MIN + PI2_STEP);
    localparam logic [WIDTH-1:0] L_FREE_DEF  = WIDTH'(FREE_DEF);
    localparam logic [WIDTH-1:0] L_FREE_MIN  = WIDTH'(FREE_MIN);
    localparam logic [WIDTH-1:0] L_FREE_MAX  = WIDTH'(FREE_MAX);
    localparam logic [WIDTH-1:0] L_FREE_STEP = WIDTH'(FREE_STEP);
    localparam logic [WIDTH-1:0] L_FREE_HI   = WIDTH'(FREE_MAX - FREE_STEP);
    localparam logic [WIDTH-1:0] L_FREE_LO   = WIDTH'(FREE_MIN + FREE_STEP);

    typedef enum logic [2:0] {
        S_PUMP  = 3'd0,
        S_DEAD1 = 3'd1,
        S_MW1   = 3'd2,
        S_FREE  = 3'd3,
        S_MW2   = 3'd4,
        S_DEAD2 = 3'd5,
        S_PROBE = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_len;
    logic             w_last;
    logic             w_seq_end;

    logic [WIDTH-1:0] r_pi2;
    logic [WIDTH-1:0] r_free;
    logic [WIDTH-1:0] r_pi2_sh;
    logic [WIDTH-1:0] r_free_sh;
    logic [WIDTH-1:0] w_pi2_inc;
    logic [WIDTH-1:0] w_pi2_dec;
    logic [WIDTH-1:0] w_free_inc;
    logic [WIDTH-1:0] w_free_dec;

    // bit 0: pi/2 plus, 1: pi/2 minus, 2: free plus, 3: free minus
    logic [3:0]       r_btn_s;
    logic [3:0]       r_btn_d;
    logic [3:0]       w_rise;

    logic             r_pump;
    logic             r_mw;
    logic             r_probe;

    // Length of the current state; MW and FREE use the per-sequence shadows
    always_comb begin
        w_len = L_PUMP;
        case (r_state)
            S_PUMP:  w_len = L_PUMP;
            S_DEAD1: w_len = L_DEAD;
            S_MW1:   w_len = r_pi2_sh;
            S_FREE:  w_len = r_free_sh;
            S_MW2:   w_len = r_pi2_sh;
            S_DEAD2: w_len = L_DEAD;
            S_PROBE: w_len = L_PROBE;
            default: w_len = L_PUMP;
        endcase
    end

    assign w_last    = (r_cnt == w_len - L_ONE);
    assign w_seq_end = w_last && (r_state == S_PROBE);

    // Next-state and count: advance when the current state has run its full length
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + L_ONE;
        if (w_last) begin
            w_cnt_nxt = '0;
            case (r_state)
                S_PUMP:  w_state_nxt = S_DEAD1;
                S_DEAD1: w_state_nxt = S_MW1;
                S_MW1:   w_state_nxt = S_FREE;
                S_FREE:  w_state_nxt = S_MW2;
                S_MW2:   w_state_nxt = S_DEAD2;
                S_DEAD2: w_state_nxt = S_PROBE;
                S_PROBE: w_state_nxt = S_PUMP;
                default: w_state_nxt = S_PUMP;
            endcase
        end
    end

    // Sequencer state register; reset parks it at the very start of PUMP
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_state <= S_PUMP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow the adjustable lengths as the sequencer wraps into PUMP
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_pi2_sh  <= L_PI2_DEF;
            r_free_sh <= L_FREE_DEF;
        end else if (w_seq_end) begin
            r_pi2_sh  <= r_pi2;
            r_free_sh <= r_free;
        end
    end

    // Gate outputs registered from the state being played out this cycle
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_pump  <= 1'b0;
            r_mw    <= 1'b0;
            r_probe <= 1'b0;
        end else begin
            r_pump  <= (r_state == S_PUMP);
            r_mw    <= (r_state == S_MW1) || (r_state == S_MW2);
            r_probe <= (r_state == S_PROBE);
        end
    end

    assign pump  = r_pump;
    assign MW    = r_mw;
    assign probe = r_probe;

`ifdef POPTIMERS_SAMPLE_EN
    localparam logic [WIDTH-1:0] L_SAMPLE_START = WIDTH'(PROBE_LEN - PROBE_LEN / 2);
    logic r_sample;

    // ADC gate covers the second half of PROBE and ends together with it
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_sample <= 1'b0;
        end else begin
            r_sample <= (r_state == S_PROBE) && (r_cnt >= L_SAMPLE_START);
        end
    end

    assign sample = r_sample;
`else
    assign sample = 1'b0;
`endif

    // Button sampling and one-cycle history for rising-edge detection
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_btn_s <= '0;
            r_btn_d <= '0;
        end else begin
            r_btn_s <= {freeprecess_minus, freeprecess_plus, pieovertwo_minus, pieovertwo_plus};
            r_btn_d <= r_btn_s;
        end
    end

    assign w_rise = r_btn_s & ~r_btn_d;

    assign w_pi2_inc  = (r_pi2 > L_PI2_HI)   ? L_PI2_MAX  : r_pi2 + L_PI2_STEP;
    assign w_pi2_dec  = (r_pi2 < L_PI2_LO)   ? L_PI2_MIN  : r_pi2 - L_PI2_STEP;
    assign w_free_inc = (r_free > L_FREE_HI) ? L_FREE_MAX : r_free + L_FREE_STEP;
    assign w_free_dec = (r_free < L_FREE_LO) ? L_FREE_MIN : r_free - L_FREE_STEP;

    // Saturating length adjust; load_defaults wins, opposing edges cancel
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            r_pi2  <= L_PI2_DEF;
            r_free <= L_FREE_DEF;
        end else if (load_defaults) begin
            r_pi2  <= L_PI2_DEF;
            r_free <= L_FREE_DEF;
        end else begin
            if (w_rise[0] && !w_rise[1]) begin
                r_pi2 <= w_pi2_inc;
            end else if (w_rise[1] && !w_rise[0]) begin
                r_pi2 <= w_pi2_dec;
            end
            if (w_rise[2] && !w_rise[3]) begin
                r_free <= w_free_inc;
            end else if (w_rise[3] && !w_rise[2]) begin
                r_free <= w_free_dec;
            end
        end
    end

endmodule

// File: tb/tb_pop_timers.sv
// tb/tb_pop_timers.sv - randomized self-checking bench for pop_timers against a timeline reference model
`timescale 1ns/1ps

module tb_pop_timers;

    localparam int PUMP_LEN  = 1000;
    localparam int DEAD_LEN  = 25;
    localparam int PROBE_LEN = 250;
    localparam int PI2_DEF   = 50;
    localparam int PI2_MIN   = 1;
    localparam int PI2_MAX   = 1000;
    localparam int FREE_DEF  = 500;
    localparam int FREE_MIN  = 10;
    localparam int FREE_MAX  = 20000;
    localparam int FREE_STEP = 10;

    logic clk_2M5           = 1'b0;
    logic reset             = 1'b1;
    logic load_defaults     = 1'b0;
    logic pieovertwo_plus   = 1'b0;
    logic pieovertwo_minus  = 1'b0;
    logic freeprecess_plus  = 1'b0;
    logic freeprecess_minus = 1'b0;
    logic pump, probe, MW, sample;
    logic [3:0] obs;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: position in the current period and the lengths in force
    int   t       = 0;
    int   sp      = PI2_DEF;
    int   sf      = FREE_DEF;
    int   m_pi2   = PI2_DEF;
    int   m_free  = FREE_DEF;
    bit   started = 0;
    int   wraps   = 0;
    int   cyc     = -1;
    logic [3:0] exp_v    = 4'b0;
    logic [3:0] prev_obs = 4'b0;
    int   g_pump_r[$];
    int   g_mw_r[$];
    int   g_mw_f[$];

    pop_timers dut (
        .clk_2M5           (clk_2M5),
        .reset             (reset),
        .load_defaults     (load_defaults),
        .pieovertwo_plus   (pieovertwo_plus),
        .pieovertwo_minus  (pieovertwo_minus),
        .freeprecess_plus  (freeprecess_plus),
        .freeprecess_minus (freeprecess_minus),
        .pump              (pump),
        .probe             (probe),
        .MW                (MW),
        .sample            (sample)
    );

    assign obs = {pump, MW, probe, sample};

    always #200 clk_2M5 = ~clk_2M5;

    function automatic int per(input int a, input int b);
        return PUMP_LEN + DEAD_LEN + a + b + a + DEAD_LEN + PROBE_LEN;
    endfunction

    // expected {pump, MW, probe, sample} at offset tt of a period with pi/2 = a, free = b
    function automatic logic [3:0] expect_at(input int tt, input int a, input int b);
        int mw1_s   = PUMP_LEN + DEAD_LEN;
        int mw2_s   = mw1_s + a + b;
        int probe_s = mw2_s + a + DEAD_LEN;
        logic [3:0] v = 4'b0;
        v[3] = (tt < PUMP_LEN);
        v[2] = (tt >= mw1_s && tt < mw1_s + a) || (tt >= mw2_s && tt < mw2_s + a);
        v[1] = (tt >= probe_s);
`ifdef POPTIMERS_SAMPLE_EN
        v[0] = (tt >= probe_s + PROBE_LEN - PROBE_LEN / 2);
`endif
        return v;
    endfunction

    // drive buttons for the next clock; the model acts on 0->1 transitions of what is driven
    task automatic drive(input bit a, input bit b, input bit c, input bit d, input bit ld);
        bit ra, rb, rc, rd;
        ra = a && !pieovertwo_plus;
        rb = b && !pieovertwo_minus;
        rc = c && !freeprecess_plus;
        rd = d && !freeprecess_minus;
        if (ld) begin
            m_pi2  = PI2_DEF;
            m_free = FREE_DEF;
        end else begin
            if (ra && !rb) m_pi2 = (m_pi2 + 1 > PI2_MAX) ? PI2_MAX : m_pi2 + 1;
            if (rb && !ra) m_pi2 = (m_pi2 - 1 < PI2_MIN) ? PI2_MIN : m_pi2 - 1;
            if (rc && !rd) m_free = (m_free + FREE_STEP > FREE_MAX) ? FREE_MAX : m_free + FREE_STEP;
            if (rd && !rc) m_free = (m_free - FREE_STEP < FREE_MIN) ? FREE_MIN : m_free - FREE_STEP;
        end
        pieovertwo_plus   = a;
        pieovertwo_minus  = b;
        freeprecess_plus  = c;
        freeprecess_minus = d;
        load_defaults     = ld;
    endtask

    // one clock: advance the model at the edge, sample the DUT at the falling edge, log output edges
    task automatic tick();
        @(posedge clk_2M5);
        if (!started) begin
            started = 1;
            t  = 0;
            sp = m_pi2;
            sf = m_free;
        end else begin
            t++;
            if (t == per(sp, sf)) begin
                t  = 0;
                sp = m_pi2;
                sf = m_free;
                wraps++;
            end
        end
        exp_v = expect_at(t, sp, sf);
        @(negedge clk_2M5);
        cyc++;
        if (pump && !prev_obs[3]) g_pump_r.push_back(cyc);
        if (MW && !prev_obs[2])   g_mw_r.push_back(cyc);
        if (!MW && prev_obs[2])   g_mw_f.push_back(cyc);
        prev_obs = obs;
    endtask

    task automatic clear_log();
        g_pump_r.delete();
        g_mw_r.delete();
        g_mw_f.delete();
    endtask

    task automatic test_reset();
        repeat (4) begin
            @(negedge clk_2M5);
            vectors++;
            if (obs !== 4'b0) begin
                miscompares++;
                $display("FAIL reset_state: outputs got %b expected 0000", obs);
            end
        end
        drive(0, 0, 0, 0, 0);
        reset    = 1'b0;
        started  = 0;
        cyc      = -1;
        prev_obs = 4'b0;
        clear_log();
    endtask

    task automatic test_first_periods();
        for (int n = 0; n <= 3800; n++) begin
            drive(0, 0, 0, 0, 0);
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL first_periods cyc=%0d: outputs got %b expected %b", cyc, obs, exp_v);
            end
            if (cyc == 1000 || cyc == 1650 || cyc == 1775 || cyc == 1899) begin
                vectors++;
                if (pump !== 1'b0 || probe !== (cyc >= 1650)) begin
                    miscompares++;
                    $display("FAIL first_periods_probe cyc=%0d: pump=%b probe=%b", cyc, pump, probe);
                end
            end
        end
        vectors++;
        if (g_pump_r.size() != 3 || g_mw_r.size() != 4 || g_mw_f.size() != 4) begin
            miscompares++;
            $display("FAIL first_periods_edges: pump rises %0d mw rises %0d falls %0d, expected 3/4/4",
                     g_pump_r.size(), g_mw_r.size(), g_mw_f.size());
        end else begin
            vectors++;
            if (g_pump_r[0] != 0 || g_pump_r[1] != 1900 || g_pump_r[2] != 3800) begin
                miscompares++;
                $display("FAIL first_periods_pump: rises %0d %0d %0d expected 0 1900 3800",
                         g_pump_r[0], g_pump_r[1], g_pump_r[2]);
            end
            vectors++;
            if (g_mw_r[0] != 1025 || g_mw_f[0] != 1075 || g_mw_r[1] != 1575 || g_mw_f[1] != 1625) begin
                miscompares++;
                $display("FAIL first_periods_mw: %0d-%0d %0d-%0d expected 1025-1075 1575-1625",
                         g_mw_r[0], g_mw_f[0], g_mw_r[1], g_mw_f[1]);
            end
        end
    endtask

    task automatic test_pi2_minus();
        int base   = cyc;
        int gap    = $urandom_range(3, 9);
        int next_p = 20;
        int done   = 0;
        clear_log();
        for (int n = 1; n <= 3792; n++) begin
            if (n == next_p && done < 4) begin
                drive(0, 1, 0, 0, 0);
                done++;
                next_p = n + gap;
            end else begin
                drive(0, 0, 0, 0, 0);
            end
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pi2_minus cyc=%0d: outputs got %b expected %b", cyc, obs, exp_v);
            end
        end
        vectors++;
        if (g_pump_r.size() != 2 || g_mw_r.size() != 4 || g_mw_f.size() != 4) begin
            miscompares++;
            $display("FAIL pi2_minus_edges: pump rises %0d mw rises %0d falls %0d, expected 2/4/4",
                     g_pump_r.size(), g_mw_r.size(), g_mw_f.size());
        end else begin
            vectors++;
            if (g_pump_r[0] - base != 1900 || g_pump_r[1] - g_pump_r[0] != 1892) begin
                miscompares++;
                $display("FAIL pi2_minus_period: got %0d then %0d expected 1900 then 1892",
                         g_pump_r[0] - base, g_pump_r[1] - g_pump_r[0]);
            end
            vectors++;
            if (g_mw_f[0] - g_mw_r[0] != 50 || g_mw_f[2] - g_mw_r[2] != 46 || g_mw_f[3] - g_mw_r[3] != 46) begin
                miscompares++;
                $display("FAIL pi2_minus_width: got %0d %0d %0d expected 50 46 46",
                         g_mw_f[0] - g_mw_r[0], g_mw_f[2] - g_mw_r[2], g_mw_f[3] - g_mw_r[3]);
            end
        end
    endtask

    task automatic test_free_plus();
        int base = cyc;
        clear_log();
        for (int n = 1; n <= 3804; n++) begin
            drive(0, 0, (n == 30 || n == 37), 0, 0);
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL free_plus cyc=%0d: outputs got %b expected %b", cyc, obs, exp_v);
            end
        end
        vectors++;
        if (g_pump_r.size() != 2 || g_mw_r.size() != 4 || g_mw_f.size() != 4) begin
            miscompares++;
            $display("FAIL free_plus_edges: pump rises %0d mw rises %0d falls %0d, expected 2/4/4",
                     g_pump_r.size(), g_mw_r.size(), g_mw_f.size());
        end else begin
            vectors++;
            if (g_pump_r[0] - base != 1892 || g_pump_r[1] - g_pump_r[0] != 1912) begin
                miscompares++;
                $display("FAIL free_plus_period: got %0d then %0d expected 1892 then 1912",
                         g_pump_r[0] - base, g_pump_r[1] - g_pump_r[0]);
            end
            vectors++;
            if (g_mw_r[1] - g_mw_f[0] != 500 || g_mw_r[3] - g_mw_f[2] != 520) begin
                miscompares++;
                $display("FAIL free_plus_gap: got %0d then %0d expected 500 then 520",
                         g_mw_r[1] - g_mw_f[0], g_mw_r[3] - g_mw_f[2]);
            end
        end
    endtask

    task automatic test_load_defaults();
        int base = cyc;
        clear_log();
        for (int n = 1; n <= 3812; n++) begin
            drive(0, 0, 0, 0, (n >= 30 && n < 40));
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL load_defaults cyc=%0d: outputs got %b expected %b", cyc, obs, exp_v);
            end
        end
        vectors++;
        if (g_pump_r.size() != 2 || g_mw_r.size() != 4 || g_mw_f.size() != 4) begin
            miscompares++;
            $display("FAIL load_defaults_edges: pump rises %0d mw rises %0d falls %0d, expected 2/4/4",
                     g_pump_r.size(), g_mw_r.size(), g_mw_f.size());
        end else begin
            vectors++;
            if (g_pump_r[0] - base != 1912 || g_pump_r[1] - g_pump_r[0] != 1900) begin
                miscompares++;
                $display("FAIL load_defaults_period: got %0d then %0d expected 1912 then 1900",
                         g_pump_r[0] - base, g_pump_r[1] - g_pump_r[0]);
            end
            vectors++;
            if (g_mw_f[2] - g_mw_r[2] != 50 || g_mw_r[3] - g_mw_f[2] != 500) begin
                miscompares++;
                $display("FAIL load_defaults_lengths: width %0d gap %0d expected 50 and 500",
                         g_mw_f[2] - g_mw_r[2], g_mw_r[3] - g_mw_f[2]);
            end
        end
    endtask

    task automatic test_saturation();
        int base = cyc;
        clear_log();
        for (int n = 1; n <= 3702; n++) begin
            if (n >= 20 && n < 200 && (n - 20) % 3 == 0) drive(0, 1, 0, 0, 0);
            else if (n == 220)                           drive(1, 1, 0, 0, 0);
            else                                         drive(0, 0, 0, 0, 0);
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL saturation cyc=%0d: outputs got %b expected %b", cyc, obs, exp_v);
            end
        end
        vectors++;
        if (g_pump_r.size() != 2 || g_mw_r.size() != 4 || g_mw_f.size() != 4) begin
            miscompares++;
            $display("FAIL saturation_edges: pump rises %0d mw rises %0d falls %0d, expected 2/4/4",
                     g_pump_r.size(), g_mw_r.size(), g_mw_f.size());
        end else begin
            vectors++;
            if (g_pump_r[1] - g_pump_r[0] != 1802 || g_mw_f[2] - g_mw_r[2] != 1 || g_mw_f[3] - g_mw_r[3] != 1) begin
                miscompares++;
                $display("FAIL saturation_pi2_min: period %0d widths %0d %0d expected 1802 1 1",
                         g_pump_r[1] - g_pump_r[0], g_mw_f[2] - g_mw_r[2], g_mw_f[3] - g_mw_r[3]);
            end
        end
    endtask

    task automatic test_held_buttons();
        int base = cyc;
        clear_log();
        for (int n = 1; n <= 3596; n++) begin
            drive((n >= 20 && n < 60), 0, 0, (n >= 20 && n < 60), 0);
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL held_buttons cyc=%0d: outputs got %b expected %b", cyc, obs, exp_v);
            end
        end
        vectors++;
        if (g_pump_r.size() != 2 || g_mw_r.size() != 4 || g_mw_f.size() != 4) begin
            miscompares++;
            $display("FAIL held_buttons_edges: pump rises %0d mw rises %0d falls %0d, expected 2/4/4",
                     g_pump_r.size(), g_mw_r.size(), g_mw_f.size());
        end else begin
            vectors++;
            if (g_pump_r[1] - g_pump_r[0] != 1794 || g_mw_f[2] - g_mw_r[2] != 2 || g_mw_r[3] - g_mw_f[2] != 490) begin
                miscompares++;
                $display("FAIL held_buttons_once: period %0d width %0d gap %0d expected 1794 2 490",
                         g_pump_r[1] - g_pump_r[0], g_mw_f[2] - g_mw_r[2], g_mw_r[3] - g_mw_f[2]);
            end
        end
    endtask

    task automatic test_random();
        int target = wraps + 4;
        int cool   = 0;
        int guard  = 0;
        bit [3:0] rb;
        while (wraps != target && guard < 20000) begin
            if (cool > 0) begin
                cool--;
                drive(0, 0, 0, 0, 0);
            end else if (t >= 10 && t < 900 && $urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    drive(0, 0, 0, 0, 1);
                end else begin
                    rb = 4'($urandom);
                    drive(rb[0], rb[1], rb[2], rb[3], 0);
                end
                cool = 3;
            end else begin
                drive(0, 0, 0, 0, 0);
            end
            tick();
            guard++;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random cyc=%0d pi2=%0d free=%0d: outputs got %b expected %b",
                         cyc, sp, sf, obs, exp_v);
            end
        end
        vectors++;
        if (wraps != target) begin
            miscompares++;
            $display("FAIL random_budget: wraps got %0d expected %0d", wraps, target);
        end
    endtask

    task automatic test_reset_mid_probe();
        int guard = 0;
        while (t != per(sp, sf) - 100 && guard < 25000) begin
            drive(0, 0, 0, 0, 0);
            tick();
            guard++;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pre_reset cyc=%0d: outputs got %b expected %b", cyc, obs, exp_v);
            end
        end
        #50 reset = 1'b1;
        #1;
        vectors++;
        if (obs !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_async: outputs got %b expected 0000 before next edge", obs);
        end
        repeat (10000) begin
            @(negedge clk_2M5);
            vectors++;
            if (obs !== 4'b0) begin
                miscompares++;
                $display("FAIL reset_hold: outputs got %b expected 0000", obs);
            end
        end
        m_pi2    = PI2_DEF;
        m_free   = FREE_DEF;
        started  = 0;
        cyc      = -1;
        prev_obs = 4'b0;
        clear_log();
        reset = 1'b0;
        for (int n = 0; n <= 1900; n++) begin
            drive(0, 0, 0, 0, 0);
            tick();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL after_reset cyc=%0d: outputs got %b expected %b", cyc, obs, exp_v);
            end
        end
        vectors++;
        if (g_pump_r.size() != 2 || g_mw_r.size() != 2) begin
            miscompares++;
            $display("FAIL after_reset_edges: pump rises %0d mw rises %0d expected 2/2",
                     g_pump_r.size(), g_mw_r.size());
        end else begin
            vectors++;
            if (g_pump_r[0] != 0 || g_pump_r[1] != 1900 || g_mw_r[0] != 1025) begin
                miscompares++;
                $display("FAIL after_reset_fresh: pump %0d,%0d mw %0d expected 0,1900 1025",
                         g_pump_r[0], g_pump_r[1], g_mw_r[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_periods();
        test_pi2_minus();
        test_free_plus();
        test_load_defaults();
        test_saturation();
        test_held_buttons();
        test_random();
        test_reset_mid_probe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pop_timers.md
POP_TIMERS -- requirements
Module: pop_timers

Interface
REQ-001 Parameter WIDTH, 16, bit width of all duration registers and counters.
REQ-002 Parameter PUMP_LEN, 1000, pump pulse length in clocks (400 us).
REQ-003 Parameter DEAD_LEN, 25, dead time in clocks (10 us): pump-to-MW1 and MW2-to-probe.
REQ-004 Parameter PROBE_LEN, 250, probe pulse length in clocks.
REQ-005 Parameter PI2_DEF, 50, default pi/2 MW pulse length; PI2_MIN 1, PI2_MAX 1000, PI2_STEP 1.
REQ-006 Parameter FREE_DEF, 500, default free-precession length; FREE_MIN 10, FREE_MAX 20000, FREE_STEP 10.
REQ-007 clk_2M5  input  1  2.5 MHz system clock; all logic on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 load_defaults  input  1  synchronous, active-high; restores the default durations.
REQ-010 pieovertwo_plus / pieovertwo_minus  input  1 each  pre-debounced buttons; increment/decrement pi/2 length.
REQ-011 freeprecess_plus / freeprecess_minus  input  1 each  pre-debounced buttons; increment/decrement free-precession length.
REQ-012 pump, probe, MW, sample  output  1 each  registered laser/microwave/ADC gate outputs.

Function
REQ-013 A free-running sequencer SHALL loop through PUMP(PUMP_LEN) -> DEAD1(DEAD_LEN) -> MW1(pi2) -> FREE(free) -> MW2(pi2) -> DEAD2(DEAD_LEN) -> PROBE(PROBE_LEN) -> PUMP, each state lasting exactly its length in clocks.
REQ-014 pump=1 only in PUMP; MW=1 only in MW1 and MW2; probe=1 only in PROBE; otherwise 0.
REQ-015 sample=1 for the final 1/2 of PROBE, i.e. its last PROBE_LEN/2 = 125 clocks, ending with probe.
REQ-016 Outputs SHALL be registered, glitch-free, and never overlap, except that sample is a subset of probe.
REQ-017 Each button SHALL act once per rising edge (0->1) detected on the sampled input; a held-high level SHALL NOT repeat; the adjusted register SHALL update on the clock after the edge is seen.
REQ-018 Adjustments SHALL saturate at MIN/MAX with no wrap-around; simultaneous plus and minus edges for the same quantity SHALL cause no change.
REQ-019 load_defaults=1 SHALL set pi2=PI2_DEF and free=FREE_DEF; it has priority over button edges in the same cycle; the sequencer keeps running.
REQ-020 pi2 and free SHALL be shadowed into working copies on entry to PUMP; changes mid-sequence take effect from the next sequence only, and MW1 and MW2 always have equal length.
REQ-021 One period at defaults is 1000+25+50+500+50+25+250 = 1900 clocks (760 us).

Reset
REQ-022 While reset=1, all outputs SHALL be 0 immediately (asynchronously), the sequencer SHALL be held in PUMP with its count at 0, the button edge detectors SHALL be cleared, and pi2/free plus the shadows SHALL take their defaults.
REQ-023 On the first clock edge after reset deasserts, pump SHALL go to 1 and a full sequence SHALL start.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence; there is no partial completion.

Configuration
REQ-025 Macro POPTIMERS_SAMPLE_EN: when defined, sample behaves per REQ-015; when undefined, sample is tied to 0 and its logic is omitted. All other behaviour is identical in both builds.

Verification
REQ-026 Release reset, then let it run 2 periods -> the following SHALL hold:
- pump high 1000 clocks;
- MW high in clocks 1025-1074 and 1575-1624;
- probe high in clocks 1650-1899;
- sample high in clocks 1775-1899;
- pump rises again at clock 1900.
REQ-027 Apply 4 separated single-clock pieovertwo_minus pulses -> pi2=46; the next sequence SHALL show both MW pulses at 46 clocks and a period of 1892.
REQ-028 Apply 2 freeprecess_plus pulses -> free=520; the next sequence SHALL have a 520-clock gap between MW pulses.
REQ-029 Assert load_defaults for 10 clocks after the adjustments -> the next sequence SHALL be back to 50/500 and a 1900-clock period.
REQ-030 Saturation and simultaneity checks:
- 60 pieovertwo_minus pulses from the default -> pi2=1;
- raising pieovertwo_plus and pieovertwo_minus on the same clock -> no change.
REQ-031 Assert reset mid-PROBE for 10000 clocks -> all outputs SHALL be 0 before the next clock edge and stay 0, with a fresh PUMP starting on the first edge after release.
